rsa_modexp_core: RTL

Parametrised successor to the fixed-width RSA go/done engine. It computes output_text = input_text^key mod mod for any WordSize using left-to-right square-and-multiply over a bit-serial interleaved modular multiplier. Operand reduction is built in, so input_text need not be less than mod. It adds a busy flag, a mod==0 error flag and an optional leading-zero exponent skip. It sits below the RFID top level and replaces its monolithic datapath/controller pair.

---
 rtl/rsa_modexp_core.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/rsa_modexp_core.sv
// rsa_modexp_core: output_text = input_text^key mod mod via left-to-right square-and-multiply
// over a bit-serial interleaved modular multiplier. Optional build macro: RSA_LEADING_ZERO_SKIP_EN.
module rsa_modexp_core #(
    parameter int WordSize = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                go,
    input  logic [WordSize-1:0] input_text,
    input  logic [WordSize-1:0] key,
    input  logic [WordSize-1:0] mod,
    output logic [WordSize-1:0] output_text,
    output logic                done,
    output logic                busy,
    output logic                err
);
    localparam int IW = $clog2(WordSize);
    localparam int RW = WordSize + 2;

    typedef enum logic [2:0] {IDLE, REDUCE, SQUARE, MULT, DONE} state_t;
    state_t state, state_next;

    logic [WordSize-1:0] key_q, mod_q, acc, base, a_sh, r, mul_b, mul_res;
    logic [RW-1:0]       m_ext, r_sum, r_sub1;
    logic [IW-1:0]       cnt, bit_idx, bit_idx_init;
    logic                start, mul_last;

    // The done cycle is still part of the operation, so go is only taken once done has dropped.
    assign start    = (state == IDLE) && go && !done;
    assign mul_last = (cnt == IW'(WordSize - 1));
    assign busy     = (state != IDLE) || done;

`ifdef RSA_LEADING_ZERO_SKIP_EN
    logic key_zero;
    assign key_zero = (key_q == '0);

    always_comb begin
        bit_idx_init = '0;
        for (int k = 0; k < WordSize; k++) begin
            if (key[k]) bit_idx_init = IW'(k);
        end
    end
`else
    assign bit_idx_init = IW'(WordSize - 1);
`endif

    // NOTE: every signal driven in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        mul_b = '0;
        case (state)
            REDUCE:  mul_b = WordSize'(1);
            SQUARE:  mul_b = acc;
            MULT:    mul_b = base;
            default: mul_b = '0;
        endcase
    end

    // One interleaved step: R <- 2R + a_j*B, then at most two subtractions of M since 2R+B < 3M.
    assign m_ext   = {2'b00, mod_q};
    assign r_sum   = {1'b0, r, 1'b0} + (a_sh[WordSize-1] ? {2'b00, mul_b} : '0);
    assign r_sub1  = (r_sum >= m_ext) ? r_sum - m_ext : r_sum;
    assign mul_res = (r_sub1 >= m_ext) ? WordSize'(r_sub1 - m_ext) : r_sub1[WordSize-1:0];

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) state_next = (mod == '0) ? DONE : REDUCE;
            end
            REDUCE: begin
`ifdef RSA_LEADING_ZERO_SKIP_EN
                if (mul_last) state_next = key_zero ? DONE : SQUARE;
`else
                if (mul_last) state_next = SQUARE;
`endif
            end
            SQUARE: begin
                if (mul_last) begin
                    if (key_q[bit_idx])      state_next = MULT;
                    else if (bit_idx == '0)  state_next = DONE;
                    else                     state_next = SQUARE;
                end
            end
            MULT: begin
                if (mul_last) state_next = (bit_idx == '0) ? DONE : SQUARE;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // NOTE: datapath registers carry no reset; an accepted go reloads all of them before use.
    always_ff @(posedge clk) begin
        case (state)
            IDLE: begin
                if (start) begin
                    key_q   <= key;
                    mod_q   <= mod;
                    acc     <= (mod <= WordSize'(1)) ? '0 : WordSize'(1);
                    bit_idx <= bit_idx_init;
                    a_sh    <= input_text;
                    r       <= '0;
                    cnt     <= '0;
                end
            end
            REDUCE, SQUARE, MULT: begin
                a_sh <= a_sh << 1;
                r    <= mul_res;
                cnt  <= cnt + IW'(1);
                if (mul_last) begin
                    cnt <= '0;
                    r   <= '0;
                    if (state == REDUCE) begin
                        base <= mul_res;
                        a_sh <= acc;
                    end else begin
                        acc  <= mul_res;
                        a_sh <= mul_res;
                        // A square followed by a multiply keeps the same exponent bit.
                        if (!(state == SQUARE && key_q[bit_idx]) && bit_idx != '0)
                            bit_idx <= bit_idx - IW'(1);
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            output_text <= '0;
            done        <= 1'b0;
            err         <= 1'b0;
        end else begin
            done <= (state == DONE);
            if (state == DONE) begin
                output_text <= acc;
                err         <= (mod_q == '0);
            end else if (start) begin
                err <= 1'b0;
            end
        end
    end
endmodule
